// File: rtl/laser_point_feeder.sv
// Point-list feeder for the LASER core: stores 40 host-written points, streams them,
// waits for DONE, captures the circle centres and scores how many points they cover.
module laser_point_feeder #(
  parameter int unsigned NPts       = 40,
  parameter int unsigned RstCycles  = 2,
  parameter int unsigned TimeoutCyc = 1023
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_en,
  input  logic [5:0] load_idx,
  input  logic [3:0] load_x,
  input  logic [3:0] load_y,
  input  logic       start,
  output logic       busy,
  output logic       laser_rst,
  output logic [3:0] x,
  output logic [3:0] y,
  input  logic       done,
  input  logic [3:0] c1x,
  input  logic [3:0] c1y,
  input  logic [3:0] c2x,
  input  logic [3:0] c2y,
  output logic [3:0] res_c1x,
  output logic [3:0] res_c1y,
  output logic [3:0] res_c2x,
  output logic [3:0] res_c2y,
  output logic [5:0] score,
  output logic       timeout,
  output logic       res_valid
);

  localparam int unsigned CntW = $clog2(TimeoutCyc + 1);

  typedef enum logic [2:0] {StIdle, StDrst, StStream, StWait, StScore, StReport} state_e;

  state_e state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [7:0] pts_q [NPts];  // {x, y}
  logic       busy_q, busy_d;
  logic       laser_rst_q, laser_rst_d;
  logic [3:0] x_q, x_d, y_q, y_d;
  logic [3:0] rc1x_q, rc1x_d, rc1y_q, rc1y_d, rc2x_q, rc2x_d, rc2y_q, rc2y_d;
  logic [5:0] score_q, score_d, acc_q, acc_d;
  logic       timeout_q, timeout_d;
  logic       res_valid_q, res_valid_d;
  logic       load_we;
  logic [5:0] idx, nidx;
  logic       cov;

  // Only offsets of 0..4 can satisfy dx^2+dy^2<=16, so larger ones reject before squaring.
  function automatic logic in_circle(logic [3:0] px, logic [3:0] py,
                                     logic [3:0] cx, logic [3:0] cy);
    logic [3:0] dx, dy;
    logic [4:0] dx5, dy5, sqx, sqy;
    logic [5:0] sum;
    dx = (px > cx) ? px - cx : cx - px;
    dy = (py > cy) ? py - cy : cy - py;
    if (dx > 4'd4 || dy > 4'd4) return 1'b0;
    dx5 = {1'b0, dx};
    dy5 = {1'b0, dy};
    sqx = dx5 * dx5;
    sqy = dy5 * dy5;
    sum = {1'b0, sqx} + {1'b0, sqy};
    return sum <= 6'd16;
  endfunction

  assign idx  = cnt_q[5:0];
  assign nidx = cnt_q[5:0] + 6'd1;
  assign cov  = in_circle(pts_q[idx][7:4], pts_q[idx][3:0], rc1x_q, rc1y_q) |
                in_circle(pts_q[idx][7:4], pts_q[idx][3:0], rc2x_q, rc2y_q);
  assign load_we = (state_q == StIdle) && load_en && (load_idx < 6'(NPts));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    busy_d      = busy_q;
    laser_rst_d = laser_rst_q;
    x_d         = x_q;
    y_d         = y_q;
    rc1x_d      = rc1x_q;
    rc1y_d      = rc1y_q;
    rc2x_d      = rc2x_q;
    rc2y_d      = rc2y_q;
    score_d     = score_q;
    acc_d       = acc_q;
    timeout_d   = timeout_q;
    res_valid_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        laser_rst_d = 1'b1;
        x_d         = 4'd0;
        y_d         = 4'd0;
        if (start) begin
          state_d   = StDrst;
          busy_d    = 1'b1;
          timeout_d = 1'b0;
          cnt_d     = '0;
        end
      end
      StDrst: begin
        if (cnt_q == CntW'(RstCycles - 1)) begin
          laser_rst_d = 1'b0;
          {x_d, y_d}  = pts_q[0];
          cnt_d       = '0;
          state_d     = StStream;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StStream: begin
        if (cnt_q == CntW'(NPts - 1)) begin
          x_d     = 4'd0;
          y_d     = 4'd0;
          cnt_d   = '0;
          state_d = StWait;
        end else begin
          {x_d, y_d} = pts_q[nidx];
          cnt_d      = cnt_q + 1'b1;
        end
      end
      StWait: begin
        if (done) begin
          rc1x_d      = c1x;
          rc1y_d      = c1y;
          rc2x_d      = c2x;
          rc2y_d      = c2y;
          acc_d       = 6'd0;
          cnt_d       = '0;
          laser_rst_d = 1'b1;
          state_d     = StScore;
        end else if (cnt_q == CntW'(TimeoutCyc)) begin
          timeout_d   = 1'b1;
          rc1x_d      = 4'd0;
          rc1y_d      = 4'd0;
          rc2x_d      = 4'd0;
          rc2y_d      = 4'd0;
          score_d     = 6'd0;
          laser_rst_d = 1'b1;
          res_valid_d = 1'b1;
          state_d     = StReport;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StScore: begin
        acc_d = acc_q + {5'd0, cov};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntW'(NPts - 1)) begin
          score_d     = acc_q + {5'd0, cov};
          res_valid_d = 1'b1;
          state_d     = StReport;
        end
      end
      StReport: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      laser_rst_q <= 1'b1;
      x_q         <= 4'd0;
      y_q         <= 4'd0;
      rc1x_q      <= 4'd0;
      rc1y_q      <= 4'd0;
      rc2x_q      <= 4'd0;
      rc2y_q      <= 4'd0;
      score_q     <= 6'd0;
      acc_q       <= 6'd0;
      timeout_q   <= 1'b0;
      res_valid_q <= 1'b0;
      for (int i = 0; i < NPts; i++) pts_q[i] <= 8'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      laser_rst_q <= laser_rst_d;
      x_q         <= x_d;
      y_q         <= y_d;
      rc1x_q      <= rc1x_d;
      rc1y_q      <= rc1y_d;
      rc2x_q      <= rc2x_d;
      rc2y_q      <= rc2y_d;
      score_q     <= score_d;
      acc_q       <= acc_d;
      timeout_q   <= timeout_d;
      res_valid_q <= res_valid_d;
      if (load_we) pts_q[load_idx] <= {load_x, load_y};
    end
  end

  assign busy      = busy_q;
  assign laser_rst = laser_rst_q;
  assign x         = x_q;
  assign y         = y_q;
  assign res_c1x   = rc1x_q;
  assign res_c1y   = rc1y_q;
  assign res_c2x   = rc2x_q;
  assign res_c2y   = rc2y_q;
  assign score     = score_q;
  assign timeout   = timeout_q;
  assign res_valid = res_valid_q;

endmodule

// File: tb/tb_laser_point_feeder.sv
// Directed bench for laser_point_feeder: drives a simple LASER responder and checks
// stream timing, scoring, timeout, ignored inputs while busy and async reset.
module tb_laser_point_feeder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       load_en = 1'b0;
  logic [5:0] load_idx = '0;
  logic [3:0] load_x = '0, load_y = '0;
  logic       start = 1'b0;
  logic       busy, laser_rst;
  logic [3:0] x, y;
  logic       done = 1'b0;
  logic [3:0] c1x = '0, c1y = '0, c2x = '0, c2y = '0;
  logic [3:0] res_c1x, res_c1y, res_c2x, res_c2y;
  logic [5:0] score;
  logic       timeout, res_valid;

  int tests = 0;
  int failed = 0;
  logic [7:0] mdl [40];

  laser_point_feeder dut (
    .clk(clk), .rst_n(rst_n), .load_en(load_en), .load_idx(load_idx),
    .load_x(load_x), .load_y(load_y), .start(start), .busy(busy),
    .laser_rst(laser_rst), .x(x), .y(y), .done(done),
    .c1x(c1x), .c1y(c1y), .c2x(c2x), .c2y(c2y),
    .res_c1x(res_c1x), .res_c1y(res_c1y), .res_c2x(res_c2x), .res_c2y(res_c2y),
    .score(score), .timeout(timeout), .res_valid(res_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_pt(input int idx, input logic [3:0] px, input logic [3:0] py);
    @(negedge clk);
    load_en  = 1'b1;
    load_idx = 6'(idx);
    load_x   = px;
    load_y   = py;
    mdl[idx] = {px, py};
  endtask

  task automatic load_end();
    @(negedge clk);
    load_en = 1'b0;
  endtask

  // done_at < 0: never raise DONE. inject_k >= 0: poke START/LOAD/DONE in that stream cycle.
  task automatic run_frame(input string nm, input int done_at,
                           input logic [3:0] a1x, input logic [3:0] a1y,
                           input logic [3:0] a2x, input logic [3:0] a2y,
                           input logic [5:0] exp_score, input int inject_k);
    int waited;
    logic exp_to;
    exp_to = (done_at < 0);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({nm, " drst0 busy/rst"}, {busy, laser_rst}, 2'b11);
    check({nm, " timeout cleared"}, timeout, 1'b0);
    @(negedge clk);
    check({nm, " drst1 rst"}, {laser_rst, x, y}, 9'h100);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      load_en = 1'b0;
      start   = 1'b0;
      done    = 1'b0;
      check($sformatf("%s stream k=%0d", nm, k), {laser_rst, x, y}, {1'b0, mdl[k]});
      if (k == inject_k) begin
        start = 1'b1; load_en = 1'b1; load_idx = 6'd0; load_x = 4'hf; load_y = 4'hf;
        done = 1'b1; c1x = 4'h1; c1y = 4'h2; c2x = 4'h3; c2y = 4'h4;
      end
    end
    @(negedge clk);
    load_en = 1'b0; start = 1'b0; done = 1'b0;
    check({nm, " wait xy"}, {laser_rst, x, y}, 9'h000);
    if (!exp_to) begin
      repeat (done_at) @(negedge clk);
      done = 1'b1; c1x = a1x; c1y = a1y; c2x = a2x; c2y = a2y;
      @(negedge clk);
      done = 1'b0;
      repeat (39) @(negedge clk);
      check({nm, " score39 rv/rst"}, {res_valid, laser_rst}, 2'b01);
      @(negedge clk);
    end else begin
      waited = 0;
      while (!res_valid && waited < 1100) begin
        @(negedge clk);
        waited++;
      end
      check({nm, " timeout cycles"}, waited, 1024);
    end
    check({nm, " report rv/busy"}, {res_valid, busy}, 2'b11);
    check({nm, " score"}, score, exp_score);
    check({nm, " timeout"}, timeout, exp_to);
    check({nm, " centres"}, {res_c1x, res_c1y, res_c2x, res_c2y},
          exp_to ? 16'h0 : {a1x, a1y, a2x, a2y});
    @(negedge clk);
    check({nm, " idle rv/busy/rst"}, {res_valid, busy, laser_rst}, 3'b001);
    check({nm, " score hold"}, score, exp_score);
  endtask

  initial begin
    for (int i = 0; i < 40; i++) mdl[i] = 8'h00;
    repeat (2) @(negedge clk);
    check("reset outputs", {busy, laser_rst, x, y, score, timeout, res_valid},
          {1'b0, 1'b1, 8'h00, 6'd0, 1'b0, 1'b0});
    check("reset centres", {res_c1x, res_c1y, res_c2x, res_c2y}, 16'h0);
    rst_n = 1'b1;

    // 1: all points on C1 centre
    for (int i = 0; i < 40; i++) load_pt(i, 4'd8, 4'd8);
    load_end();
    run_frame("t1", 5, 4'd8, 4'd8, 4'd0, 4'd0, 6'd40, -1);

    // 2: ramp pattern; 13 points within radius 4 of the origin
    for (int i = 0; i < 40; i++) load_pt(i, 4'(i % 16), 4'(i / 16));
    load_end();
    run_frame("t2", 0, 4'd0, 4'd0, 4'd0, 4'd0, 6'd13, -1);

    // 3: boundary points around C1=(5,5)
    for (int i = 0; i < 40; i++) load_pt(i, 4'd15, 4'd0);
    load_pt(0, 4'd9, 4'd5);
    load_pt(1, 4'd8, 4'd7);
    load_pt(2, 4'd8, 4'd8);
    load_pt(3, 4'd5, 4'd1);
    load_end();
    run_frame("t3", 2, 4'd5, 4'd5, 4'd15, 4'd15, 6'd3, -1);

    // 4: DONE never arrives
    run_frame("t4", -1, 4'd0, 4'd0, 4'd0, 4'd0, 6'd0, -1);

    // 5: START/LOAD/DONE while streaming are ignored
    run_frame("t5", 3, 4'd5, 4'd5, 4'd15, 4'd15, 6'd3, 10);
    run_frame("t5b", 1, 4'd5, 4'd5, 4'd15, 4'd15, 6'd3, -1);

    // 6: async reset at stream cycle 20
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (22) @(negedge clk);
    check("t6 pre-reset stream", {laser_rst, x, y}, {1'b0, mdl[20]});
    rst_n = 1'b0;
    #1;
    check("t6 async reset outputs", {busy, laser_rst, x, y, score, timeout, res_valid},
          {1'b0, 1'b1, 8'h00, 6'd0, 1'b0, 1'b0});
    check("t6 async reset centres", {res_c1x, res_c1y, res_c2x, res_c2y}, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) mdl[i] = 8'h00;
    repeat (5) @(negedge clk);
    check("t6 no res_valid", {res_valid, busy}, 2'b00);
    run_frame("t6", 1, 4'd0, 4'd0, 4'd9, 4'd9, 6'd40, -1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
